move_controller: RTL and testbench

//  Turn and board-state stage of the tic-tac-toe datapath, directly upstream of the illegal-move checker.

---
 rtl/ttt_pkg.sv | 16 +
 rtl/pos_decoder.sv | 17 +
 rtl/move_controller.sv | 152 +++++++++++++++
 tb/tb_move_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe constants: square codes, square count and controller state encoding.
package ttt_pkg;

  localparam logic [1:0] EMPTY   = 2'b00;
  localparam logic [1:0] P1_CODE = 2'b01;
  localparam logic [1:0] P2_CODE = 2'b10;

  localparam int unsigned NUM_SQUARES = 9;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StEval   = 2'd1,
    StLocked = 2'd2
  } state_e;

endpackage

// File: rtl/pos_decoder.sv
// Square number (1..9) to one-hot square enable; anything else decodes to zero with valid low.
module pos_decoder (
  input  logic [3:0] play_pos,
  output logic [8:0] onehot,
  output logic       valid
);

  always_comb begin
    onehot = '0;
    valid  = 1'b0;
    if (play_pos >= 4'd1 && play_pos <= 4'd9) begin
      valid  = 1'b1;
      onehot = 9'd1 << (play_pos - 4'd1);
    end
  end

endmodule

// File: rtl/move_controller.sv
// Turn and board-state stage: decodes a move request, presents it to the illegal-move checker,
// then commits or rejects it on the checker's verdict one cycle later.
module move_controller #(
  parameter logic [1:0]  P1_CODE   = ttt_pkg::P1_CODE,
  parameter logic [1:0]  P2_CODE   = ttt_pkg::P2_CODE,
  parameter int unsigned MAX_MOVES = 9
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       new_game,
  input  logic       play_req,
  input  logic [3:0] play_pos,
  input  logic       illegal,
  input  logic       game_over,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic [8:0] Play1_en,
  output logic [8:0] Play2_en,
  output logic       turn,
  output logic       move_done,
  output logic       move_rej,
  output logic       board_full,
  output logic       locked
);

  import ttt_pkg::*;

  localparam logic [3:0] MaxCnt = 4'(MAX_MOVES);

  state_e     state_q, state_d;
  logic [1:0] board_q [NUM_SQUARES];
  logic [1:0] board_d [NUM_SQUARES];
  logic [8:0] sel_q, sel_d;
  logic [8:0] p1_en_q, p1_en_d, p2_en_q, p2_en_d;
  logic       bad_pos_q, bad_pos_d;
  logic       turn_q, turn_d;
  logic [3:0] count_q, count_d;
  logic       done_q, done_d, rej_q, rej_d;

  logic [8:0] dec_onehot;
  logic       dec_valid;

  pos_decoder u_pos_decoder (
    .play_pos (play_pos),
    .onehot   (dec_onehot),
    .valid    (dec_valid)
  );

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    sel_d     = sel_q;
    bad_pos_d = bad_pos_q;
    turn_d    = turn_q;
    count_d   = count_q;
    p1_en_d   = '0;
    p2_en_d   = '0;
    done_d    = 1'b0;
    rej_d     = 1'b0;

    if (new_game) begin
      board_d   = '{default: EMPTY};
      sel_d     = '0;
      bad_pos_d = 1'b0;
      turn_d    = 1'b0;
      count_d   = '0;
      state_d   = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (game_over) begin
            state_d = StLocked;
          end else if (play_req) begin
            sel_d     = dec_onehot;
            bad_pos_d = !dec_valid;
            if (!turn_q) p1_en_d = dec_onehot;
            else         p2_en_d = dec_onehot;
            state_d = StEval;
          end
        end
        StEval: begin
          // The checker's verdict is on the enables registered last cycle.
          if (illegal || bad_pos_q) begin
            rej_d = 1'b1;
          end else begin
            for (int unsigned k = 0; k < NUM_SQUARES; k++) begin
              if (sel_q[k]) board_d[k] = turn_q ? P2_CODE : P1_CODE;
            end
            turn_d  = !turn_q;
            count_d = (count_q >= MaxCnt) ? count_q : count_q + 4'd1;
            done_d  = 1'b1;
          end
          state_d = (game_over || count_d == MaxCnt) ? StLocked : StIdle;
        end
        StLocked: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      board_q   <= '{default: EMPTY};
      sel_q     <= '0;
      bad_pos_q <= 1'b0;
      turn_q    <= 1'b0;
      count_q   <= '0;
      p1_en_q   <= '0;
      p2_en_q   <= '0;
      done_q    <= 1'b0;
      rej_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      sel_q     <= sel_d;
      bad_pos_q <= bad_pos_d;
      turn_q    <= turn_d;
      count_q   <= count_d;
      p1_en_q   <= p1_en_d;
      p2_en_q   <= p2_en_d;
      done_q    <= done_d;
      rej_q     <= rej_d;
    end
  end

  assign pos1 = board_q[0];
  assign pos2 = board_q[1];
  assign pos3 = board_q[2];
  assign pos4 = board_q[3];
  assign pos5 = board_q[4];
  assign pos6 = board_q[5];
  assign pos7 = board_q[6];
  assign pos8 = board_q[7];
  assign pos9 = board_q[8];

  assign Play1_en   = p1_en_q;
  assign Play2_en   = p2_en_q;
  assign turn       = turn_q;
  assign move_done  = done_q;
  assign move_rej   = rej_q;
  assign board_full = (count_q == MaxCnt);
  assign locked     = (state_q == StLocked);

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: directed scenarios plus random play, checked against a game-level model.
module tb_move_controller;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       new_game = 1'b0;
  logic       play_req = 1'b0;
  logic [3:0] play_pos = 4'd0;
  logic       illegal = 1'b0;
  logic       game_over = 1'b0;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic [8:0] Play1_en, Play2_en;
  logic       turn, move_done, move_rej, board_full, locked;

  move_controller dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .new_game   (new_game),
    .play_req   (play_req),
    .play_pos   (play_pos),
    .illegal    (illegal),
    .game_over  (game_over),
    .pos1       (pos1),
    .pos2       (pos2),
    .pos3       (pos3),
    .pos4       (pos4),
    .pos5       (pos5),
    .pos6       (pos6),
    .pos7       (pos7),
    .pos8       (pos8),
    .pos9       (pos9),
    .Play1_en   (Play1_en),
    .Play2_en   (Play2_en),
    .turn       (turn),
    .move_done  (move_done),
    .move_rej   (move_rej),
    .board_full (board_full),
    .locked     (locked)
  );

  always #5 clock = ~clock;

  // Game-level model: board contents, whose turn, moves made, and a request awaiting its verdict.
  int board [1:9];
  bit m_turn;
  int m_count;
  bit m_pending;
  int m_pend;
  bit m_locked, m_done, m_rej;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit sq_ok(input int p);
    return p >= 1 && p <= 9;
  endfunction

  task automatic model_clear();
    for (int k = 1; k <= 9; k++) board[k] = 0;
    m_turn = 0; m_count = 0; m_pending = 0; m_pend = 0;
    m_locked = 0; m_done = 0; m_rej = 0;
  endtask

  task automatic model_edge(input bit ng, input bit req, input int p, input bit ill, input bit go);
    m_done = 0;
    m_rej  = 0;
    if (ng) begin
      model_clear();
    end else if (m_locked) begin
    end else if (m_pending) begin
      m_pending = 0;
      if (ill || !sq_ok(m_pend)) begin
        m_rej = 1;
      end else begin
        board[m_pend] = m_turn ? 2 : 1;
        m_turn = !m_turn;
        if (m_count < 9) m_count++;
        m_done = 1;
      end
      if (go || m_count == 9) m_locked = 1;
    end else if (go) begin
      m_locked = 1;
    end else if (req) begin
      m_pending = 1;
      m_pend = p;
    end
  endtask

  task automatic check_outputs();
    logic [17:0] exp_pos;
    logic [8:0]  exp_en;
    exp_pos = '0;
    for (int k = 1; k <= 9; k++) exp_pos[2*(k-1) +: 2] = 2'(board[k]);
    exp_en = (m_pending && sq_ok(m_pend)) ? (9'd1 << (m_pend - 1)) : 9'd0;
    check("board", {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1}, exp_pos);
    check("play1_en", Play1_en, m_turn ? 9'd0 : exp_en);
    check("play2_en", Play2_en, m_turn ? exp_en : 9'd0);
    check("turn", turn, m_turn);
    check("move_done", move_done, m_done);
    check("move_rej", move_rej, m_rej);
    check("board_full", board_full, m_count == 9);
    check("locked", locked, m_locked);
  endtask

  // One clock: drive at the negedge, model the edge, check at the following negedge.
  task automatic step(input bit ng, input bit req, input logic [3:0] p, input bit force_ill,
                      input bit go);
    bit ill;
    ill = force_ill || (m_pending && sq_ok(m_pend) && board[m_pend] != 0);
    new_game = ng; play_req = req; play_pos = p; illegal = ill; game_over = go;
    @(posedge clock);
    model_edge(ng, req, int'(p), ill, go);
    @(negedge clock);
    new_game = 0; play_req = 0; illegal = 0; game_over = 0;
    check_outputs();
  endtask

  task automatic move(input logic [3:0] p);
    step(0, 1, p, 0, 0);
    step(0, 0, 4'd0, 0, 0);
  endtask

  int seq [9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};

  initial begin
    model_clear();
    #2;
    check_outputs();
    @(negedge clock);
    reset_n = 1;

    // first move to the centre, then the opponent tries the same square
    step(0, 1, 4'd5, 0, 0);
    check("t1_p1en", Play1_en, 9'h010);
    step(0, 0, 4'd0, 0, 0);
    check("t1_pos5", pos5, 2'b01);
    step(0, 1, 4'd5, 0, 0);
    check("t2_p2en", Play2_en, 9'h010);
    step(0, 0, 4'd0, 0, 0);
    check("t2_rej", move_rej, 1'b1);

    // out-of-range squares
    move(4'd0);
    move(4'd12);
    move(4'd10);

    // full board with no line
    step(1, 0, 4'd0, 0, 0);
    for (int i = 0; i < 9; i++) move(4'(seq[i]));
    check("t4_full", board_full, 1'b1);
    check("t4_locked", locked, 1'b1);
    step(0, 1, 4'd3, 0, 0);
    step(0, 0, 4'd0, 0, 0);

    // win reported during the commit, then a fresh game
    step(1, 0, 4'd0, 0, 0);
    step(0, 1, 4'd1, 0, 0);
    step(0, 0, 4'd0, 0, 1);
    check("t5_locked", locked, 1'b1);
    step(0, 1, 4'd2, 0, 0);
    step(1, 0, 4'd0, 0, 0);
    check("t5_turn", turn, 1'b0);

    // request during EVAL is dropped; new_game beats a commit
    step(0, 1, 4'd3, 0, 0);
    step(0, 1, 4'd4, 0, 0);
    step(0, 0, 4'd0, 0, 0);
    step(0, 0, 4'd0, 0, 0);
    step(0, 1, 4'd6, 0, 0);
    step(1, 0, 4'd0, 0, 0);
    check("t6_pos6", pos6, 2'b00);

    // asynchronous reset while a move is under evaluation
    step(0, 1, 4'd7, 0, 0);
    reset_n = 0;
    #1;
    model_clear();
    check_outputs();
    @(negedge clock);
    reset_n = 1;
    step(0, 0, 4'd0, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 1) == 1),
           4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
